// File: rtl/bus_region_decoder_pkg.sv
// Shared types and default memory map for the 6809 region decoder.
package bus_decode_pkg;

  localparam int WAIT_W        = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_N_REGIONS = 6;

  // Region 0 occupies the least significant slice of each packed vector.
  localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {16'hA002, 16'hA001, 16'hA000, 16'h3000, 16'h1000, 16'h8000};
  localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF000, 16'hF000, 16'hC000};
  localparam logic [DEF_N_REGIONS*WAIT_W-1:0] DEF_REGION_WAIT =
    {4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd1};
  localparam logic [DEF_N_REGIONS-1:0] DEF_EXT_GATE = 6'b000100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } state_e;

endpackage

// File: rtl/bus_region_decoder_if.sv
// 6809-side bus bundle of the region decoder: CPU inputs and chip-enable/MRDY outputs.
interface bus_region_decoder_if
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int N_REGIONS = DEF_N_REGIONS
);
  logic [ADDR_W-1:0]    i_address;
  logic                 i_enable;
  logic                 i_Q;
  logic                 i_E;
  logic                 i_ext_cs_n;
  logic [N_REGIONS-1:0] o_ce;
  logic                 o_mrdy;
  logic                 o_busy;
  logic                 o_fault;
  logic [ADDR_W-1:0]    o_fault_addr;

  modport slave (
    input  i_address, i_enable, i_Q, i_E, i_ext_cs_n,
    output o_ce, o_mrdy, o_busy, o_fault, o_fault_addr
  );

  modport master (
    output i_address, i_enable, i_Q, i_E, i_ext_cs_n,
    input  o_ce, o_mrdy, o_busy, o_fault, o_fault_addr
  );
endinterface

// File: rtl/bus_region_decoder_region_match.sv
// Combinational base/mask compare array with external-master gating and lowest-index priority.
module region_match
  import bus_decode_pkg::*;
#(
  parameter int                          ADDR_W      = DEF_ADDR_W,
  parameter int                          N_REGIONS   = DEF_N_REGIONS,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [N_REGIONS-1:0]        EXT_GATE    = DEF_EXT_GATE
) (
  input  logic [ADDR_W-1:0]    i_address,
  input  logic                 i_ext_cs_n,
  output logic                 o_hit,
  output logic [N_REGIONS-1:0] o_onehot
);

  logic [N_REGIONS-1:0] w_match;

  for (genvar n = 0; n < N_REGIONS; n++) begin : g_cmp
    assign w_match[n] =
      ((i_address & REGION_MASK[n*ADDR_W +: ADDR_W]) == REGION_BASE[n*ADDR_W +: ADDR_W]) &&
      !(EXT_GATE[n] && !i_ext_cs_n);
  end

  // Isolating the lowest set bit gives the priority winner directly.
  assign o_onehot = w_match & (~w_match + {{(N_REGIONS-1){1'b0}}, 1'b1});
  assign o_hit    = |w_match;

endmodule

// File: rtl/bus_region_decoder.sv
// Registered 6809 region decoder: Q-rise address latch, one-hot CE, per-region MRDY wait states.
// Optional sticky unmapped-access capture is built when ACCESS_FAULT_EN is defined.
module bus_region_decoder
  import bus_decode_pkg::*;
#(
  parameter int                          ADDR_W      = DEF_ADDR_W,
  parameter int                          N_REGIONS   = DEF_N_REGIONS,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT = DEF_REGION_WAIT,
  parameter logic [N_REGIONS-1:0]        EXT_GATE    = DEF_EXT_GATE
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  bus_region_decoder_if.slave  io_bus
);

  state_e               r_state, w_state_nxt;
  logic                 r_q, r_e;
  logic [ADDR_W-1:0]    r_addr;
  logic [N_REGIONS-1:0] r_ce, w_ce_nxt;
  logic [WAIT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                 r_gated, w_gated_nxt;
  logic                 r_mrdy;
  logic                 w_latch, w_hit, w_drop;
  logic                 w_q_rise, w_e_fall;
  logic [N_REGIONS-1:0] w_onehot;
  logic [WAIT_W-1:0]    w_wait;

  region_match #(
    .ADDR_W      (ADDR_W),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .EXT_GATE    (EXT_GATE)
  ) u_match (
    .i_address  (r_addr),
    .i_ext_cs_n (io_bus.i_ext_cs_n),
    .o_hit      (w_hit),
    .o_onehot   (w_onehot)
  );

  always_comb begin
    w_wait = '0;
    for (int n = 0; n < N_REGIONS; n++)
      if (w_onehot[n]) w_wait = w_wait | REGION_WAIT[n*WAIT_W +: WAIT_W];
  end

  // Q/E copies follow the pins through reset so a level held across reset is not seen as an edge.
  always_ff @(posedge i_clk) begin
    r_q <= io_bus.i_Q;
    r_e <= io_bus.i_E;
    if (w_latch) r_addr <= io_bus.i_address;
  end

  assign w_q_rise = io_bus.i_Q & ~r_q;
  assign w_e_fall = ~io_bus.i_E & r_e;
  assign w_drop   = r_gated & ~io_bus.i_ext_cs_n;

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = r_ce;
    w_cnt_nxt   = r_cnt;
    w_gated_nxt = r_gated;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ce_nxt = '0;
        if (w_q_rise && io_bus.i_enable) begin
          w_latch     = 1'b1;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (!w_hit) begin
          w_state_nxt = IDLE;
          w_ce_nxt    = '0;
        end else begin
          w_ce_nxt    = w_onehot;
          w_gated_nxt = |(w_onehot & EXT_GATE);
          if (w_wait == '0) begin
            w_state_nxt = ACTIVE;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = w_wait;
          end
        end
      end
      WAIT: begin
        if (w_drop) begin
          w_state_nxt = IDLE;
          w_ce_nxt    = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end
      end
      ACTIVE: begin
        if (w_drop || w_e_fall || !io_bus.i_enable) begin
          w_state_nxt = IDLE;
          w_ce_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ce_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ce    <= '0;
      r_cnt   <= '0;
      r_gated <= 1'b0;
      r_mrdy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= w_ce_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gated <= w_gated_nxt;
      r_mrdy  <= (w_state_nxt != WAIT);
    end
  end

  assign io_bus.o_ce   = r_ce;
  assign io_bus.o_mrdy = r_mrdy;
  assign io_bus.o_busy = (r_state != IDLE);

`ifdef ACCESS_FAULT_EN
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_addr;
  logic              w_fault_set;

  assign w_fault_set = (r_state == DECODE) && !w_hit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
      if (!r_fault) r_fault_addr <= r_addr;
    end
  end

  assign io_bus.o_fault      = r_fault;
  assign io_bus.o_fault_addr = r_fault_addr;
`else
  assign io_bus.o_fault      = 1'b0;
  assign io_bus.o_fault_addr = '0;
`endif

endmodule

// File: tb/tb_bus_region_decoder.sv
// Self-checking bench for bus_region_decoder: vector table, hand sequences, randomized transactions.
module tb_bus_region_decoder;
  import bus_decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] address;
  logic        enable, q, e, ext_cs_n;
  int          n_checks = 0;
  int          n_err    = 0;

`ifdef ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  bus_region_decoder_if #(.ADDR_W(16), .N_REGIONS(6)) bus_a ();
  bus_region_decoder_if #(.ADDR_W(16), .N_REGIONS(2)) bus_b ();

  assign bus_a.i_address  = address;
  assign bus_a.i_enable   = enable;
  assign bus_a.i_Q        = q;
  assign bus_a.i_E        = e;
  assign bus_a.i_ext_cs_n = ext_cs_n;
  assign bus_b.i_address  = address;
  assign bus_b.i_enable   = enable;
  assign bus_b.i_Q        = q;
  assign bus_b.i_E        = e;
  assign bus_b.i_ext_cs_n = ext_cs_n;

  bus_region_decoder u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_a));

  // Overlapping map: both regions decode 0x1xxx, region 0 carries the maximum wait of 15.
  bus_region_decoder #(
    .ADDR_W(16), .N_REGIONS(2),
    .REGION_BASE(32'h1000_1000), .REGION_MASK(32'hF000_F000),
    .REGION_WAIT(8'h0F), .EXT_GATE(2'b00)
  ) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_b));

  // Reference memory map, region 0 first.
  logic [15:0] m_base [6] = '{16'h8000, 16'h1000, 16'h3000, 16'hA000, 16'hA001, 16'hA002};
  logic [15:0] m_mask [6] = '{16'hC000, 16'hF000, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  int          m_wait [6] = '{1, 0, 3, 0, 0, 0};
  bit          m_gate [6] = '{0, 0, 1, 0, 0, 0};
  bit          m_fault      = 1'b0;
  logic [15:0] m_fault_addr = 16'h0;

  typedef struct {
    logic [15:0] addr;
    logic        ext;
    logic [5:0]  ce;
    int          w;
  } vec_t;

  vec_t vecs [12];

  function automatic int model_region(input logic [15:0] a, input logic ext);
    for (int n = 0; n < 6; n++)
      if (((a & m_mask[n]) == m_base[n]) && !(m_gate[n] && !ext)) return n;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_fault      = 1'b0;
    m_fault_addr = 16'h0;
  endtask

  task automatic check_fault(input string name);
    check({name, " fault"},      bus_a.o_fault,      m_fault);
    check({name, " fault_addr"}, bus_a.o_fault_addr, m_fault_addr);
  endtask

  // One complete bus cycle on DUT A: Q-rise, decode, waits, E-fall.
  task automatic run_txn(input string name, input logic [15:0] a, input logic ext,
                         input logic [5:0] exp_ce, input int exp_w);
    int lows;
    bit held;
    enable = 1'b1; q = 1'b0; e = 1'b0; address = a; ext_cs_n = ext;
    step();
    q = 1'b1;
    step();
    check({name, " busy in decode"}, bus_a.o_busy, 1);
    step();
    q = 1'b0;
    check({name, " ce"}, bus_a.o_ce, exp_ce);
    if (exp_ce == 6'b0) begin
      check({name, " idle after miss"}, bus_a.o_busy, 0);
      if (FAULT_EN && !m_fault) begin
        m_fault      = 1'b1;
        m_fault_addr = a;
      end
    end else begin
      lows = 0;
      held = 1'b1;
      while (bus_a.o_mrdy == 1'b0 && lows < 40) begin
        if (bus_a.o_ce !== exp_ce) held = 1'b0;
        lows++;
        step();
      end
      check({name, " mrdy low cycles"}, lows, exp_w);
      check({name, " ce held through wait"}, held, 1);
      e = 1'b1;
      step();
      check({name, " ce held until E-fall"}, bus_a.o_ce, exp_ce);
      e = 1'b0;
      step();
      check({name, " ce cleared on E-fall"}, bus_a.o_ce, 0);
      check({name, " idle after E-fall"}, bus_a.o_busy, 0);
    end
    check_fault(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lows;
    int          r;
    logic [15:0] a;
    logic        x;
    logic [5:0]  ce;

    vecs[0]  = '{16'h1234, 1'b1, 6'b000010, 0};
    vecs[1]  = '{16'h3010, 1'b1, 6'b000100, 3};
    vecs[2]  = '{16'h3010, 1'b0, 6'b000000, 0};
    vecs[3]  = '{16'hA001, 1'b1, 6'b000001, 1};
    vecs[4]  = '{16'h5000, 1'b1, 6'b000000, 0};
    vecs[5]  = '{16'h9000, 1'b1, 6'b000001, 1};
    vecs[6]  = '{16'hBFFF, 1'b0, 6'b000001, 1};
    vecs[7]  = '{16'hC000, 1'b1, 6'b000000, 0};
    vecs[8]  = '{16'h1FFF, 1'b0, 6'b000010, 0};
    vecs[9]  = '{16'h0FFF, 1'b1, 6'b000000, 0};
    vecs[10] = '{16'h3FFF, 1'b1, 6'b000100, 3};
    vecs[11] = '{16'h2000, 1'b1, 6'b000000, 0};

    address = 16'h0; enable = 1'b0; q = 1'b0; e = 1'b0; ext_cs_n = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    check("reset ce",         bus_a.o_ce,         0);
    check("reset mrdy",       bus_a.o_mrdy,       1);
    check("reset busy",       bus_a.o_busy,       0);
    check("reset fault",      bus_a.o_fault,      0);
    check("reset fault_addr", bus_a.o_fault_addr, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ext, vecs[i].ce, vecs[i].w);

    // First unmapped access is captured, later misses do not overwrite it.
    do_reset();
    run_txn("fault first hit", 16'hA001, 1'b1, 6'b000001, 1);
    run_txn("fault miss 5000", 16'h5000, 1'b1, 6'b000000, 0);
    run_txn("fault miss 6000", 16'h6000, 1'b1, 6'b000000, 0);
    check("fault keeps first addr", bus_a.o_fault_addr, FAULT_EN ? 32'h5000 : 32'h0);

    // External master takes the flash during the wait of a gated region.
    enable = 1'b1; e = 1'b0; address = 16'h3010; ext_cs_n = 1'b1; q = 1'b0;
    step();
    q = 1'b1; step(); step();
    check("gate drop in wait mrdy", bus_a.o_mrdy, 0);
    ext_cs_n = 1'b0;
    step();
    check("gate drop ce",   bus_a.o_ce,   0);
    check("gate drop mrdy", bus_a.o_mrdy, 1);
    check("gate drop busy", bus_a.o_busy, 0);
    ext_cs_n = 1'b1; q = 1'b0;
    step();

    // Address moves after the latch; Q-rise in ACTIVE must not re-decode.
    q = 1'b1; address = 16'h1234;
    step();
    address = 16'h5000; q = 1'b0;
    step();
    check("late addr ignored", bus_a.o_ce, 6'b000010);
    q = 1'b1;
    step();
    check("qrise in active ignored", bus_a.o_ce, 6'b000010);
    enable = 1'b0;
    step();
    check("enable low ends cycle", bus_a.o_ce, 0);
    check("enable low idle", bus_a.o_busy, 0);
    q = 1'b0; step();
    q = 1'b1; address = 16'h1234;
    step(); step();
    check("no decode without enable", bus_a.o_busy, 0);
    check("no ce without enable", bus_a.o_ce, 0);

    // Reset in the middle of a wait.
    enable = 1'b1; q = 1'b0; address = 16'h3010;
    step();
    q = 1'b1; step(); step();
    check("pre-reset mrdy low", bus_a.o_mrdy, 0);
    rst_n = 1'b0;
    m_fault = 1'b0; m_fault_addr = 16'h0;
    step();
    check("mid-wait reset ce",   bus_a.o_ce,   0);
    check("mid-wait reset mrdy", bus_a.o_mrdy, 1);
    check("mid-wait reset busy", bus_a.o_busy, 0);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_a.o_ce !== 6'b0 || bus_a.o_busy !== 1'b0) lows++;
    end
    check("no strobe after reset release", lows, 0);
    q = 1'b0;
    step();

    // Randomized transactions against the map model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) a = m_base[r] | (16'($urandom) & ~m_mask[r]);
      else a = 16'($urandom);
      x  = 1'($urandom_range(0, 1));
      r  = model_region(a, x);
      ce = (r < 0) ? 6'b0 : (6'b1 << r);
      run_txn($sformatf("rand%0d", i), a, x, ce, (r < 0) ? 0 : m_wait[r]);
    end

    // Overlapping regions on DUT B: region 0 wins and waits the full 15 cycles.
    enable = 1'b0; q = 1'b0; e = 1'b0;
    for (int i = 0; i < 20; i++) step();
    enable = 1'b1; address = 16'h1000; ext_cs_n = 1'b1;
    q = 1'b1; step(); step();
    q = 1'b0;
    check("overlap ce lowest wins", bus_b.o_ce, 2'b01);
    lows = 0;
    while (bus_b.o_mrdy == 1'b0 && lows < 40) begin
      lows++;
      step();
    end
    check("wait 15 low cycles", lows, 15);
    check("wait 15 ce held", bus_b.o_ce, 2'b01);
    e = 1'b1; step();
    e = 1'b0; step();
    check("overlap ce cleared", bus_b.o_ce, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
